pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried by the stage.
REQ-002 Parameter RESET_DATA, default 0 (DATA_W bits), payload value loaded on reset and flush.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  stage presents a payload.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  DATA_W  payload presented downstream.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Accept = in_valid && in_ready; release = out_valid && out_ready; both evaluated in the same cycle.
REQ-014 Storage: main entry (drives out_valid/out_data) plus skid entry; occupancy = main_valid + skid_valid.
REQ-015 in_ready SHALL be a registered signal equal to !skid_valid, with no combinational path from out_ready.
REQ-016 Accept with main empty, or main released in the same cycle and skid empty: payload loads main next cycle.
REQ-017 Accept with main held and not released: payload loads skid; in_ready deasserts next cycle.
REQ-018 Release with skid valid: skid moves to main next cycle; skid clears; in_ready reasserts next cycle.
REQ-019 Skid is never loaded while valid; the accept rules in REQ-016/REQ-017 guarantee this.
REQ-020 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-021 Ordering strictly FIFO; no payload dropped or duplicated except by flush.
REQ-022 Latency: accepted payload visible on out_data one cycle after accept when main is empty.
REQ-023 Throughput: one payload per cycle sustained when out_ready is continuously high.
REQ-024 flush has priority over accept and release: next cycle main_valid=0, skid_valid=0, both data=RESET_DATA, in_ready=1, occupancy=0; a payload offered in the flush cycle is discarded.
REQ-025 With out_valid=0, out_data SHALL equal RESET_DATA or the last released payload, and out_data is not to be sampled.

Reset
REQ-026 rst asserted: out_valid=0, out_data=RESET_DATA, skid data=RESET_DATA, in_ready=1, occupancy=0, taking effect immediately without waiting for clk.
REQ-027 rst asserted mid-transfer discards all held entries; first accept possible on the first posedge after rst deasserts.

Configuration
REQ-028 Macro PIPE_STAGE_REG_SKID_EN defined: two-entry behaviour per REQ-014 to REQ-024.
REQ-029 Macro undefined: skid entry is absent, in_ready = !out_valid || out_ready (combinational), occupancy maximum 1, occupancy[1] tied 0; REQ-020 to REQ-025 still apply.

Verification
REQ-030 DATA_W=32, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready stays 1.
REQ-031 SKID_EN, out_ready=0, offer 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB released, in_ready=1 one cycle after first release.
REQ-032 occupancy 2, assert flush together with in_valid (data 0xC) and out_ready -> next cycle occupancy 0, out_valid=0, in_ready=1, 0xC never appears.
REQ-033 Assert rst between clock edges while occupancy=1 -> out_valid=0 and out_data=RESET_DATA immediately; no output before a new accept.
REQ-034 Random in_valid/out_ready for 10000 cycles -> scoreboard shows in-order, lossless delivery and no out_data change while stalled.
REQ-035 Build without SKID_EN, out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 combinationally and a new payload is accepted in that cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register stage.
// Build option PIPE_STAGE_REG_SKID_EN:
//   defined   - two entries (main + skid). in_ready is registered and has no
//               combinational path from out_ready.
//   undefined - single main entry. in_ready = !out_valid || out_ready
//               (combinational) and occupancy never exceeds 1.
// flush is the synchronous discard of all held entries and overrides accept
// and release. rst is an asynchronous active-high reset.
module pipe_stage_reg #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main entry: always drives out_valid/out_data.
    logic              main_valid_r;
    logic [DATA_W-1:0] main_data_r;
    logic              main_valid_nxt_s;
    logic [DATA_W-1:0] main_data_nxt_s;

    // Handshake qualifiers for the current cycle.
    logic              accept_s;
    logic              release_s;

    assign release_s = main_valid_r && out_ready;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

`ifdef PIPE_STAGE_REG_SKID_EN

    // Skid entry catches the payload accepted while main is stalled.
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              skid_valid_nxt_s;
    logic [DATA_W-1:0] skid_data_nxt_s;
    logic              in_ready_r;
    logic [1:0]        occupancy_r;

    // in_ready is a flop, so upstream never sees out_ready combinationally.
    assign accept_s  = in_valid && in_ready_r;
    assign in_ready  = in_ready_r;
    assign occupancy = occupancy_r;

    // Next-state selection for both entries; flush overrides every transfer.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_data_nxt_s  = main_data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            main_data_nxt_s  = RESET_DATA;
            skid_valid_nxt_s = 1'b0;
            skid_data_nxt_s  = RESET_DATA;
        end else if (release_s && skid_valid_r) begin
            // in_ready is low while skid is full, so no accept can collide here.
            main_valid_nxt_s = 1'b1;
            main_data_nxt_s  = skid_data_r;
            skid_valid_nxt_s = 1'b0;
        end else if (accept_s && (!main_valid_r || release_s)) begin
            main_valid_nxt_s = 1'b1;
            main_data_nxt_s  = in_data;
        end else if (accept_s) begin
            // Main held and stalled: park the payload in the (empty) skid.
            skid_valid_nxt_s = 1'b1;
            skid_data_nxt_s  = in_data;
        end else if (release_s) begin
            // Data is kept so out_data shows the last released payload.
            main_valid_nxt_s = 1'b0;
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // State registers; in_ready and occupancy are derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= RESET_DATA;
            skid_valid_r <= 1'b0;
            skid_data_r  <= RESET_DATA;
            in_ready_r   <= 1'b1;
            occupancy_r  <= 2'd0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_data_r  <= main_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            occupancy_r  <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
        end
    end

`else

    // Single entry: accept whenever main is empty or drains this cycle.
    assign in_ready  = !main_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign occupancy = {1'b0, main_valid_r};

    // Next-state selection for the main entry; flush overrides every transfer.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_data_nxt_s  = main_data_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            main_data_nxt_s  = RESET_DATA;
        end else if (accept_s) begin
            main_valid_nxt_s = 1'b1;
            main_data_nxt_s  = in_data;
        end else if (release_s) begin
            // Data is kept so out_data shows the last released payload.
            main_valid_nxt_s = 1'b0;
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // Main entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= RESET_DATA;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_data_r  <= main_data_nxt_s;
        end
    end

`endif

endmodule
